kred_share_arbiter: RTL and testbench

- Shares one two-stage K-2RED modular reduction pipeline (24-bit product in, 12-bit coefficient out, fixed 2-cycle latency) between NREQ requesters, e.g. NTT butterfly lanes and the pointwise multiplier.
- Grants one operand per cycle using round-robin, with optional bounded burst lock.
- Tags each issued operand and returns the reduced result to the originating requester.
- The reducer is instantiated outside this block; this block drives its input and samples its result.

---
 rtl/kred_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_kred_share_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kred_share_arbiter.sv
// Round-robin arbiter sharing one external K-2RED reducer between NREQ requesters,
// with bounded burst lock and id-tagged result return. Optional counters: KRED_SHARE_STATS_EN.
module kred_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int RED_LAT   = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*24-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [23:0]          red_in,
  input  logic [11:0]          red_res,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [11:0]          rsp_data,
  output logic                 busy
`ifdef KRED_SHARE_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_issued,
  output logic [15:0]          stat_stall
`endif
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] lock_owner;
  logic            lock_v;
  logic [BW-1:0]   burst_cnt;
  tag_t            tag_q [RED_LAT];

  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] scan_idx;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] owner_oh;
  logic            hold_lock;
  logic            tag_any;

  // Handshake: requester i transfers its operand in a cycle where req_valid[i] & req_ready[i];
  // req_ready is one-hot or zero and may depend combinationally on req_valid of that cycle.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    owner_oh  = NREQ'(1) << lock_owner;
    cand      = req_valid;
    hold_lock = lock_v && req_valid[lock_owner] && req_lock[lock_owner] && (burst_cnt < BMAX);
    // An exhausted burst rotates away from the owner unless it is the only one asking.
    if (lock_v && (burst_cnt >= BMAX) && ((req_valid & ~owner_oh) != '0))
      cand = req_valid & ~owner_oh;
    // Nothing is granted while reset is held.
    if (rst_n) begin
      if (hold_lock) begin
        grant_any = 1'b1;
        grant_id  = lock_owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          scan_idx = ID_W'((int'(rr_ptr) + k) % NREQ);
          if (!grant_any && cand[scan_idx]) begin
            grant_any = 1'b1;
            grant_id  = scan_idx;
          end
        end
      end
    end
  end

  assign req_ready = grant_any ? (NREQ'(1) << grant_id) : '0;
  assign red_in    = grant_any ? req_data[grant_id*24 +: 24] : 24'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lock_owner <= '0;
      lock_v     <= 1'b0;
      burst_cnt  <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
      if (req_lock[grant_id]) begin
        lock_v     <= 1'b1;
        lock_owner <= grant_id;
        if (lock_v && (lock_owner == grant_id) && (burst_cnt < BMAX))
          burst_cnt <= burst_cnt + BW'(1);
        else
          burst_cnt <= BW'(1);
      end else begin
        lock_v     <= 1'b0;
        lock_owner <= '0;
        burst_cnt  <= '0;
      end
    end else if (lock_v && !req_valid[lock_owner]) begin
      lock_v     <= 1'b0;
      lock_owner <= '0;
      burst_cnt  <= '0;
    end
  end

  // Last tag stage lines up with red_res for the operand it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RED_LAT; i++) tag_q[i] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      tag_q[0] <= '{v: grant_any, id: grant_id};
      for (int i = 1; i < RED_LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid <= tag_q[RED_LAT-1].v;
      if (tag_q[RED_LAT-1].v) begin
        rsp_id   <= tag_q[RED_LAT-1].id;
        rsp_data <= red_res;
      end
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < RED_LAT; i++) tag_any = tag_any | tag_q[i].v;
  end

  assign busy = tag_any | rsp_valid;

`ifdef KRED_SHARE_STATS_EN
  logic stall_any;
  assign stall_any = (req_valid & ~req_ready) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else if (stat_clr) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant_any && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
      if (stall_any && stat_stall != 16'hFFFF)  stat_stall  <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kred_share_arbiter.sv
// Directed bench for kred_share_arbiter with a two-stage mod-3329 reducer model on the side.
// Define KRED_SHARE_STATS_EN to also exercise the statistics counters.
module tb_kred_share_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*24-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [23:0]        red_in;
  logic [11:0]        red_res;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [11:0]        rsp_data;
  logic               busy;
`ifdef KRED_SHARE_STATS_EN
  logic               stat_clr;
  logic [15:0]        stat_issued;
  logic [15:0]        stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] tv [16];
  logic [3:0] tl [16];
  logic [3:0] te [16];
  int         tn;

  kred_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lock(req_lock), .req_data(req_data),
    .req_ready(req_ready), .red_in(red_in), .red_res(red_res),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
`ifdef KRED_SHARE_STATS_EN
    , .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External reducer model: operand sampled on one edge, result valid after the next
  logic [23:0] red_s1;
  logic [11:0] red_s2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_s1 <= '0;
      red_s2 <= '0;
    end else begin
      red_s1 <= red_in;
      red_s2 <= 12'(red_s1 % 24'd3329);
    end
  end
  assign red_res = red_s2;

  function automatic logic [11:0] red_model(input logic [23:0] x);
    return 12'(x % 24'd3329);
  endfunction

  function automatic logic [23:0] dval(input int i, input int j);
    return 24'(i * 40000 + j * 1000 + 7);
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
`ifdef KRED_SHARE_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (red_in !== 24'd0) begin errors++; $display("FAIL reset_red_in: got %h expected 0", red_in); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0 || rsp_data !== 12'd0) begin errors++; $display("FAIL reset_rsp: got id %0d data %h expected 0/0", rsp_id, rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    repeat (2) @(negedge clk);
    req_data[1*24 +: 24] = 24'h000D05;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
    checks++; if (red_in !== 24'h000D05) begin errors++; $display("FAIL single_red_in: got %h expected 000d05", red_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_t0: got %b expected 0", busy); end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_t1: got busy %b rsp_valid %b expected 1/0", busy, rsp_valid); end
    checks++; if (req_ready !== 4'b0000 || red_in !== 24'd0) begin errors++; $display("FAIL single_idle: got ready %b red_in %h expected 0000/0", req_ready, red_in); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_t2: got busy %b rsp_valid %b expected 1/0", busy, rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL single_rsp: got valid %b id %0d expected 1/1", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 12'd4) begin errors++; $display("FAIL single_data: got %0d expected 4", rsp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t3: got %b expected 1", busy); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_t4: got valid %b busy %b expected 0/0", rsp_valid, busy); end
    checks++; if (rsp_data !== 12'd4) begin errors++; $display("FAIL single_hold: got %0d expected 4", rsp_data); end
  endtask

  task automatic test_round_robin();
    int g;
    int r;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i < 8) begin
        req_valid = 4'b1111;
        for (int j = 0; j < NREQ; j++) req_data[j*24 +: 24] = dval(i, j);
      end else begin
        req_valid = '0;
      end
      #1;
      if (i < 8) begin
        g = i % 4;
        checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, 4'(1 << g)); end
        checks++; if (red_in !== dval(i, g)) begin errors++; $display("FAIL rr_red_in[%0d]: got %h expected %h", i, red_in, dval(i, g)); end
      end
      if (i >= 3) begin
        r = (i - 3) % 4;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(r) || rsp_data !== red_model(dval(i - 3, r))) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: got v%b id%0d data %h expected v1 id%0d data %h",
                   i, rsp_valid, rsp_id, rsp_data, r, red_model(dval(i - 3, r)));
        end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
      end
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    tn = 11;
    tv[0] = 4'b0100;
    for (int i = 1; i < 11; i++) tv[i] = 4'b1101;
    for (int i = 0; i < 11; i++) tl[i] = 4'b0100;
    te[0] = 4'b0100; te[1] = 4'b0100; te[2] = 4'b0100; te[3] = 4'b0100;
    te[4] = 4'b1000; te[5] = 4'b0001;
    te[6] = 4'b0100; te[7] = 4'b0100; te[8] = 4'b0100; te[9] = 4'b0100;
    te[10] = 4'b1000;
    for (int i = 0; i < tn; i++) begin
      @(negedge clk); req_valid = tv[i]; req_lock = tl[i]; #1;
      checks++; if (req_ready !== te[i]) begin errors++; $display("FAIL burst_grant[%0d]: got %b expected %b", i, req_ready, te[i]); end
    end
    req_valid = '0; req_lock = '0;
  endtask

  task automatic test_owner_alone();
    do_reset();
    tn = 9;
    for (int i = 0; i < 9; i++) begin
      tv[i] = (i < 5) ? 4'b0100 : 4'b1100;
      tl[i] = 4'b0100;
      te[i] = (i < 8) ? 4'b0100 : 4'b1000;
    end
    for (int i = 0; i < tn; i++) begin
      @(negedge clk); req_valid = tv[i]; req_lock = tl[i]; #1;
      checks++; if (req_ready !== te[i]) begin errors++; $display("FAIL alone_grant[%0d]: got %b expected %b", i, req_ready, te[i]); end
    end
    req_valid = '0; req_lock = '0;
  endtask

  task automatic test_lock_drop();
    do_reset();
    tn = 9;
    tv[0] = 4'b0100; tv[1] = 4'b0101; tv[2] = 4'b0000;
    for (int i = 3; i < 9; i++) tv[i] = 4'b0101;
    for (int i = 0; i < 9; i++) tl[i] = 4'b0100;
    te[0] = 4'b0100; te[1] = 4'b0100; te[2] = 4'b0000; te[3] = 4'b0001;
    te[4] = 4'b0100; te[5] = 4'b0100; te[6] = 4'b0100; te[7] = 4'b0100;
    te[8] = 4'b0001;
    for (int i = 0; i < tn; i++) begin
      @(negedge clk); req_valid = tv[i]; req_lock = tl[i]; #1;
      checks++; if (req_ready !== te[i]) begin errors++; $display("FAIL drop_grant[%0d]: got %b expected %b", i, req_ready, te[i]); end
    end
    req_valid = '0; req_lock = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int j = 0; j < NREQ; j++) req_data[j*24 +: 24] = dval(1, j);
    @(negedge clk); req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mrst_g0: got %b expected 0001", req_ready); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mrst_g1: got %b expected 0010", req_ready); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++;
    if (req_ready !== 4'b0000 || red_in !== 24'd0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        rsp_id !== 2'd0 || rsp_data !== 12'd0) begin
      errors++;
      $display("FAIL mrst_outputs: got ready %b red_in %h v %b busy %b id %0d data %h expected all 0",
               req_ready, red_in, rsp_valid, busy, rsp_id, rsp_data);
    end
    @(negedge clk); rst_n = 1'b1; req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_stale[%0d]: got v %b busy %b expected 0/0", i, rsp_valid, busy); end
      @(negedge clk);
    end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mrst_first: got %b expected 0001", req_ready); end
    @(negedge clk); req_valid = '0;
  endtask

`ifdef KRED_SHARE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); req_valid = 4'b0111;
    end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (stat_issued !== 16'd10) begin errors++; $display("FAIL stat_issued10: got %0d expected 10", stat_issued); end
    checks++; if (stat_stall !== 16'd10) begin errors++; $display("FAIL stat_stall10: got %0d expected 10", stat_stall); end
    stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0; #1;
    checks++; if (stat_issued !== 16'd0 || stat_stall !== 16'd0) begin errors++; $display("FAIL stat_clr: got %0d/%0d expected 0/0", stat_issued, stat_stall); end
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk); req_valid = 4'b0011;
    end
    @(negedge clk); req_valid = '0; #1;
    checks++; if (stat_issued !== 16'hFFFF || stat_stall !== 16'hFFFF) begin errors++; $display("FAIL stat_sat: got %h/%h expected ffff/ffff", stat_issued, stat_stall); end
    stat_clr = 1'b1; req_valid = 4'b0011;
    @(negedge clk); stat_clr = 1'b0; req_valid = '0; #1;
    checks++; if (stat_issued !== 16'd0 || stat_stall !== 16'd0) begin errors++; $display("FAIL stat_clr_prio: got %0d/%0d expected 0/0", stat_issued, stat_stall); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_lock = '0;
    req_data = '0;
`ifdef KRED_SHARE_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_owner_alone();
    test_lock_drop();
    test_mid_reset();
`ifdef KRED_SHARE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
